// File: rtl/dmem_arbiter_if.sv
// Data-memory arbiter bus: two requester ports, the RAM port and debug.
// master = requesters/RAM side, slave = arbiter side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              rvalid0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata1;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic [1:0]        starve_cnt;

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output ram_rdata,
        input  gnt0, rvalid0, rdata0,
        input  gnt1, rvalid1, rdata1,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        input  starve_cnt
    );

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  ram_rdata,
        output gnt0, rvalid0, rdata0,
        output gnt1, rvalid1, rdata1,
        output ram_en, ram_we, ram_addr, ram_wdata,
        output starve_cnt
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: port 0 fixed priority, port 1 aged.
// Read data returns to the issuing port one cycle after its grant.
module dmem_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 3
) (
    input logic         clk,
    input logic         rst,
    dmem_arbiter_if.slave bus
);
    localparam logic [1:0] LIMIT = 2'(STARVE_LIMIT);

    logic [1:0]        cnt_q;
    logic              tag_vld_q;
    logic              tag_port_q;
    logic [DATA_W-1:0] hold0_q;
    logic [DATA_W-1:0] hold1_q;

    logic              forced;
    logic              g0;
    logic              g1;
    logic              hit0;
    logic              hit1;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    assign forced = bus.req1 && (cnt_q == LIMIT);

    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (!rst) begin
            if (forced) begin
                g1 = 1'b1;
            end else if (bus.req0) begin
                g0 = 1'b1;
            end else if (bus.req1) begin
                g1 = 1'b1;
            end
        end
    end

    always_comb begin
        r_we    = 1'b0;
        r_addr  = '0;
        r_wdata = '0;
        if (g0) begin
            r_we    = bus.we0;
            r_addr  = bus.addr0;
            r_wdata = bus.wdata0;
        end else if (g1) begin
            r_we    = bus.we1;
            r_addr  = bus.addr1;
            r_wdata = bus.wdata1;
        end
    end

    // A tag still pending while rst is high is dropped, not returned.
    assign hit0 = tag_vld_q && !tag_port_q && !rst;
    assign hit1 = tag_vld_q &&  tag_port_q && !rst;

    assign bus.gnt0       = g0;
    assign bus.gnt1       = g1;
    assign bus.ram_en     = g0 | g1;
    assign bus.ram_we     = r_we;
    assign bus.ram_addr   = r_addr;
    assign bus.ram_wdata  = r_wdata;
    assign bus.rvalid0    = hit0;
    assign bus.rvalid1    = hit1;
    assign bus.rdata0     = hit0 ? bus.ram_rdata : hold0_q;
    assign bus.rdata1     = hit1 ? bus.ram_rdata : hold1_q;
    assign bus.starve_cnt = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= 2'd0;
            tag_vld_q  <= 1'b0;
            tag_port_q <= 1'b0;
            hold0_q    <= '0;
            hold1_q    <= '0;
        end else begin
            if (bus.req1 && !g1) begin
                cnt_q <= (cnt_q >= LIMIT) ? LIMIT : cnt_q + 2'd1;
            end else begin
                cnt_q <= 2'd0;
            end
            tag_vld_q  <= (g0 | g1) && !r_we;
            tag_port_q <= g1;
            if (hit0) hold0_q <= bus.ram_rdata;
            if (hit1) hold1_q <= bus.ram_rdata;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-level reference model.
module tb_dmem_arbiter;
    localparam int LIM = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    dmem_arbiter #(
        .ADDR_W(8),
        .DATA_W(32),
        .STARVE_LIMIT(LIM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    function automatic logic [31:0] init_val(input int a);
        return 32'hA500_0000 ^ (a * 32'h0101_0101);
    endfunction

    // Synchronous-read RAM attached to the arbiter
    logic [31:0] mem [256];
    logic        mem_wr [256];
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) begin
                mem[bus.ram_addr]    <= bus.ram_wdata;
                mem_wr[bus.ram_addr] <= 1'b1;
            end else begin
                bus.ram_rdata <= (mem_wr[bus.ram_addr] === 1'b1) ?
                                 mem[bus.ram_addr] : init_val(int'(bus.ram_addr));
            end
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [31:0] sh [256];
    int          m_cnt = 0;
    bit          pv    = 0;
    int          pp    = 0;
    logic [31:0] pd    = '0;
    logic [31:0] h0    = '0;
    logic [31:0] h1    = '0;

    task automatic step(input bit r,
                        input bit q0, input bit w0,
                        input logic [7:0] a0, input logic [31:0] d0,
                        input bit q1, input bit w1,
                        input logic [7:0] a1, input logic [31:0] d1,
                        output int win);
        bit          ev0, ev1, wwe;
        logic [7:0]  wa;
        logic [31:0] wd;
        rst = r;
        bus.req0 = q0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
        bus.req1 = q1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
        #3;
        if (r) win = -1;
        else if (q1 && m_cnt >= LIM) win = 1;
        else if (q0) win = 0;
        else if (q1) win = 1;
        else win = -1;
        wwe = (win == 0) ? w0 : (win == 1) ? w1 : 1'b0;
        wa  = (win == 0) ? a0 : (win == 1) ? a1 : 8'd0;
        wd  = (win == 0) ? d0 : (win == 1) ? d1 : 32'd0;
        ev0 = !r && pv && pp == 0;
        ev1 = !r && pv && pp == 1;

        chk("gnt0", 32'(bus.gnt0), 32'(win == 0));
        chk("gnt1", 32'(bus.gnt1), 32'(win == 1));
        chk("ram_en", 32'(bus.ram_en), 32'(win >= 0));
        chk("ram_we", 32'(bus.ram_we), 32'(wwe));
        chk("ram_addr", 32'(bus.ram_addr), 32'(wa));
        if (wwe) chk("ram_wdata", bus.ram_wdata, wd);
        chk("rvalid0", 32'(bus.rvalid0), 32'(ev0));
        chk("rvalid1", 32'(bus.rvalid1), 32'(ev1));
        if (!r) begin
            chk("starve_cnt", 32'(bus.starve_cnt), 32'(m_cnt));
            chk("rdata0", bus.rdata0, ev0 ? pd : h0);
            chk("rdata1", bus.rdata1, ev1 ? pd : h1);
        end

        if (r) begin
            m_cnt = 0; pv = 0; h0 = '0; h1 = '0;
        end else begin
            if (ev0) h0 = pd;
            if (ev1) h1 = pd;
            pv = 0;
            if (win >= 0) begin
                if (wwe) sh[wa] = wd;
                else begin
                    pv = 1; pp = win; pd = sh[wa];
                end
            end
            if (q1 && win != 1) m_cnt = (m_cnt + 1 > LIM) ? LIM : m_cnt + 1;
            else m_cnt = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(output int win);
        step(0, 0, 0, 8'd0, 32'd0, 0, 0, 8'd0, 32'd0, win);
    endtask

    initial begin
        int w;
        int n1;
        for (int i = 0; i < 256; i++) sh[i] = init_val(i);
        bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
        @(posedge clk);
        #1;
        step(1, 0, 0, 8'd0, 32'd0, 0, 0, 8'd0, 32'd0, w);
        step(1, 1, 0, 8'd1, 32'd0, 1, 0, 8'd2, 32'd0, w);
        chk("reset_cnt", 32'(bus.starve_cnt), 32'd0);
        chk("reset_rdata0", bus.rdata0, 32'd0);

        // port 0 write then read back
        step(0, 1, 1, 8'd5, 32'hDEADBEEF, 0, 0, 8'd0, 32'd0, w);
        step(0, 1, 0, 8'd5, 32'd0, 0, 0, 8'd0, 32'd0, w);
        idle(w);
        chk("p0_rd5", bus.rdata0, 32'hDEADBEEF);

        // both request continuously: port 1 gets every 4th cycle
        n1 = 0;
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 0, 8'(i % 8), 32'd0, 1, 0, 8'd100, 32'd0, w);
            if (w == 1) n1++;
        end
        chk("p1_share", 32'(n1), 32'd3);
        idle(w);

        // interleaved reads, no cross-routing
        step(0, 1, 1, 8'd2, 32'h11, 0, 0, 8'd0, 32'd0, w);
        step(0, 1, 1, 8'd3, 32'h22, 0, 0, 8'd0, 32'd0, w);
        step(0, 1, 0, 8'd0, 32'd0, 1, 0, 8'd3, 32'd0, w);
        step(0, 1, 0, 8'd1, 32'd0, 1, 0, 8'd3, 32'd0, w);
        step(0, 1, 0, 8'd2, 32'd0, 1, 0, 8'd3, 32'd0, w);
        step(0, 1, 0, 8'd4, 32'd0, 1, 0, 8'd3, 32'd0, w);
        chk("forced_win", 32'(w), 32'd1);
        idle(w);
        chk("il_rdata0", bus.rdata0, 32'h11);
        chk("il_rdata1", bus.rdata1, 32'h22);

        // port 1 write seen by port 0 read
        step(0, 0, 0, 8'd0, 32'd0, 1, 1, 8'd9, 32'h5A5A5A5A, w);
        step(0, 1, 0, 8'd9, 32'd0, 0, 0, 8'd0, 32'd0, w);
        idle(w);
        chk("p1w_p0r", bus.rdata0, 32'h5A5A5A5A);

        // reset right after a read grant
        step(0, 1, 0, 8'd5, 32'd0, 1, 0, 8'd7, 32'd0, w);
        step(1, 1, 0, 8'd6, 32'd0, 1, 0, 8'd7, 32'd0, w);
        idle(w);
        chk("rst_cnt", 32'(bus.starve_cnt), 32'd0);

        // req1 dropped at starve_cnt = 2
        step(0, 1, 0, 8'd1, 32'd0, 1, 1, 8'd50, 32'h77, w);
        step(0, 1, 0, 8'd1, 32'd0, 1, 1, 8'd50, 32'h77, w);
        chk("cnt_two", 32'(bus.starve_cnt), 32'd2);
        step(0, 1, 0, 8'd1, 32'd0, 0, 1, 8'd50, 32'h77, w);
        chk("drop_cnt", 32'(bus.starve_cnt), 32'd0);
        idle(w);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0),
                 1'($urandom), 1'($urandom), 8'($urandom_range(0, 15)), $urandom,
                 1'($urandom), 1'($urandom), 8'($urandom_range(0, 15)), $urandom,
                 w);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: port 0 is the core load/store path, and port 1 is the host/loader path that preloads or inspects data memory.
- Each cycle it issues at most one RAM command. Port 0 has fixed priority, and an aging counter guarantees port 1 forward progress.
- Read data comes back on a 1-cycle-latency valid strobe to the port that issued the read.

Parameters:
ADDR_W, 8, data-memory word address width (256 words)
DATA_W, 32, data word width
STARVE_LIMIT, 3, number of consecutive cycles port 1 may be denied while requesting before it is forced to win

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
req0  in  1  port 0 request; held with cmd fields stable until gnt0
we0  in  1  port 0: 1 = write, 0 = read
addr0  in  ADDR_W  port 0 word address
wdata0  in  DATA_W  port 0 write data
gnt0  out  1  port 0 command accepted this cycle (combinational)
rvalid0  out  1  port 0 read data valid (registered)
rdata0  out  DATA_W  port 0 read data, valid when rvalid0
req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1  same as port 0, for port 1
ram_en  out  1  RAM command strobe
ram_we  out  1  RAM write enable, qualified by ram_en
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid the cycle after a read command (synchronous read)
starve_cnt  out  2  current port-1 aging count, debug/observability

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high.
- Reset values (rst high at a rising edge):
  - rvalid0 = rvalid1 = 0, rdata0 = rdata1 = 0
  - starve_cnt = 0, read-tag register = none
- While rst is high, gnt0, gnt1 and ram_en are forced to 0.
- Arbitration, combinational, evaluated each cycle:
  - Port 1 is "forced" when starve_cnt == STARVE_LIMIT and req1 = 1.
  - Forced: gnt1 = 1, gnt0 = 0.
  - Otherwise, if req0: gnt0 = 1.
  - Otherwise, if req1: gnt1 = 1.
  - At most one of gnt0/gnt1 is ever high.
- RAM command: ram_en = gnt0 | gnt1; ram_we/ram_addr/ram_wdata are muxed from the granted port. With no grant, ram_we = 0 and addr/wdata = 0.
- Aging counter, on each edge:
  - req1 && !gnt1 → starve_cnt += 1, saturating at STARVE_LIMIT.
  - gnt1 or !req1 → starve_cnt = 0.
- Read return:
  - A granted read (we = 0) registers a tag (port id, valid).
  - Next cycle: rvalidN = 1 for the tagged port only, and rdataN = ram_rdata, also registered into rdataN.
  - rdata of the non-tagged port holds its previous value.
- Writes produce no rvalid. A write is complete at the edge where it is granted.
- Throughput:
  - One command per cycle, back-to-back reads allowed.
  - Read results arrive in issue order, each exactly 1 cycle after its grant.
- Requester rules: after gnt, a requester may present a new command in the very next cycle. Dropping req before gnt is allowed; the command is simply not issued.
- Same-address conflict: a write by one port and a read by the other in consecutive cycles follow RAM order. A read granted after the write's grant cycle returns the new data.
- Reset mid-operation: an outstanding read tag is discarded, and no rvalid is asserted in the cycle after reset.
- STARVE_LIMIT = 0: port 1 wins every cycle it requests. This is legal, and gives port 1 priority.

Test Plan:
- Port 0 alone: write addr 5 = 0xDEADBEEF, next cycle read addr 5 → gnt0 both cycles; rvalid0 = 1 with rdata0 = 0xDEADBEEF one cycle after the read grant; rvalid1 stays 0.
- Both ports request continuously (port 0 reads addr 0..7, port 1 reads addr 100), STARVE_LIMIT = 3 → port 1 is granted on every 4th cycle; starve_cnt sequence 0,1,2,3,0; port 0 is never granted in the forced cycle.
- Interleaved reads: port 0 reads addr 2 (0x11) in cycle N, port 1 reads addr 3 (0x22) in forced cycle N+1 → rvalid0/rdata0 = 0x11 at N+1, rvalid1/rdata1 = 0x22 at N+2, no cross-routing.
- Port 1 writes addr 9 = 0x5A5A5A5A while port 0 is idle, then port 0 reads addr 9 → rdata0 = 0x5A5A5A5A.
- Assert rst for one cycle directly after a port 0 read grant → no rvalid0 the following cycle; starve_cnt = 0; gnt0 = gnt1 = 0 during the rst cycle.
- req1 dropped before being granted while starve_cnt = 2 → starve_cnt returns to 0; no RAM command is issued for port 1.
